// File: rtl/fifo_pkg.sv
// Shared helpers for the parametrised FIFO: address sizing, depth legality, error status bit names.
package fifo_pkg;

  typedef enum logic [0:0] {
    ERR_OVF = 1'b0,
    ERR_UNF = 1'b1
  } err_bit_e;

  function automatic int addr_w(input int depth);
    return (depth > 1) ? $clog2(depth) : 1;
  endfunction

  function automatic bit depth_ok(input int depth);
    return (depth >= 2) && (depth <= 4096) && ((depth & (depth - 1)) == 0);
  endfunction

endpackage

// File: rtl/fifo_ram.sv
// WIDTH x DEPTH simple dual-port array: synchronous write, asynchronous read, no reset.
module fifo_ram #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 16,
  parameter int AW    = 4
) (
  input  logic             clk,
  input  logic             we_i,
  input  logic [AW-1:0]    waddr_i,
  input  logic [WIDTH-1:0] wdata_i,
  input  logic [AW-1:0]    raddr_i,
  output logic [WIDTH-1:0] rdata_o
);

  logic [WIDTH-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (we_i) mem[waddr_i] <= wdata_i;
  end

  assign rdata_o = mem[raddr_i];

endmodule

// File: rtl/fifo_sync_param.sv
// Single-clock FIFO with occupancy, threshold flags, sticky error flags and synchronous flush.
// Define FIFO_FWFT_EN for first-word-fall-through output; otherwise data_out is a 1-cycle registered read.
module fifo_sync_param
  import fifo_pkg::*;
#(
  parameter int WIDTH     = 8,
  parameter int DEPTH     = 16,
  parameter int AF_MARGIN = 2,
  parameter int AE_MARGIN = 2
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   flush,
  input  logic [WIDTH-1:0]       data_in,
  input  logic                   wr,
  input  logic                   rd,
  output logic [WIDTH-1:0]       data_out,
  output logic                   full,
  output logic                   empty,
  output logic                   almost_full,
  output logic                   almost_empty,
  output logic [$clog2(DEPTH):0] count,
  output logic                   overflow,
  output logic                   underflow
);

  localparam int AW     = addr_w(DEPTH);
  localparam int CW     = AW + 1;
  localparam int AF_LVL = DEPTH - AF_MARGIN;

  if (!depth_ok(DEPTH)) begin : g_bad_depth
    $error("fifo_sync_param: DEPTH must be a power of two in 2..4096");
  end
  if (WIDTH < 1 || WIDTH > 256) begin : g_bad_width
    $error("fifo_sync_param: WIDTH must be in 1..256");
  end

  logic [CW-1:0]    wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d, count_q, count_d;
  logic             full_q, full_d, empty_q, empty_d, af_q, af_d, ae_q, ae_d;
  logic             ovf_q, ovf_d, unf_q, unf_d;
  logic             wr_acc, rd_acc;
  logic [WIDTH-1:0] rdata;

  always_comb begin
    // A write into a full FIFO is still taken when a read frees the head slot the same edge.
    wr_acc   = !flush && wr && (!full_q || rd);
    rd_acc   = !flush && rd && !empty_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    ovf_d    = ovf_q;
    unf_d    = unf_q;
    if (flush) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
      ovf_d    = 1'b0;
      unf_d    = 1'b0;
    end else begin
      if (wr_acc) wr_ptr_d = wr_ptr_q + CW'(1);
      if (rd_acc) rd_ptr_d = rd_ptr_q + CW'(1);
      count_d = count_q + CW'(wr_acc) - CW'(rd_acc);
      ovf_d   = ovf_q | (wr && full_q && !rd);
      unf_d   = unf_q | (rd && empty_q);
    end
    full_d  = (count_d == CW'(DEPTH));
    empty_d = (count_d == '0);
    af_d    = (int'(count_d) >= AF_LVL);
    ae_d    = (int'(count_d) <= AE_MARGIN);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      full_q   <= 1'b0;
      empty_q  <= 1'b1;
      af_q     <= 1'b0;
      ae_q     <= 1'b1;
      ovf_q    <= 1'b0;
      unf_q    <= 1'b0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      full_q   <= full_d;
      empty_q  <= empty_d;
      af_q     <= af_d;
      ae_q     <= ae_d;
      ovf_q    <= ovf_d;
      unf_q    <= unf_d;
    end
  end

  fifo_ram #(
    .WIDTH (WIDTH),
    .DEPTH (DEPTH),
    .AW    (AW)
  ) u_ram (
    .clk     (clk),
    .we_i    (wr_acc),
    .waddr_i (wr_ptr_q[AW-1:0]),
    .wdata_i (data_in),
    .raddr_i (rd_ptr_q[AW-1:0]),
    .rdata_o (rdata)
  );

`ifdef FIFO_FWFT_EN
  // Head is shown straight from the array; the last head is held once the FIFO drains.
  logic [WIDTH-1:0] hold_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst)           hold_q <= '0;
    else if (!empty_q) hold_q <= rdata;
  end

  assign data_out = empty_q ? hold_q : rdata;
`else
  logic [WIDTH-1:0] dout_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst)         dout_q <= '0;
    else if (rd_acc) dout_q <= rdata;
  end

  assign data_out = dout_q;
`endif

  assign full         = full_q;
  assign empty        = empty_q;
  assign almost_full  = af_q;
  assign almost_empty = ae_q;
  assign count        = count_q;
  assign overflow     = ovf_q;
  assign underflow    = unf_q;

endmodule

// File: tb/tb_fifo_sync_param.sv
// Directed plus randomized bench for fifo_sync_param against a queue-based reference model.
module tb_fifo_sync_param;
  import fifo_pkg::*;

  localparam int WIDTH = 8;
  localparam int DEPTH = 16;
  localparam int AF_MARGIN = 2;
  localparam int AE_MARGIN = 2;
  localparam int CW = $clog2(DEPTH) + 1;

  logic             clk = 1'b0;
  logic             rst, flush, wr, rd;
  logic [WIDTH-1:0] data_in;
  logic [WIDTH-1:0] data_out;
  logic             full, empty, almost_full, almost_empty, overflow, underflow;
  logic [CW-1:0]    count;

  int n_vec = 0;
  int n_err = 0;

  logic [WIDTH-1:0] mq [$];
  logic             m_ovf, m_unf;
  logic [WIDTH-1:0] m_dout, m_last;
  logic [1:0]       err_vec;

  fifo_sync_param #(
    .WIDTH     (WIDTH),
    .DEPTH     (DEPTH),
    .AF_MARGIN (AF_MARGIN),
    .AE_MARGIN (AE_MARGIN)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .flush        (flush),
    .data_in      (data_in),
    .wr           (wr),
    .rd           (rd),
    .data_out     (data_out),
    .full         (full),
    .empty        (empty),
    .almost_full  (almost_full),
    .almost_empty (almost_empty),
    .count        (count),
    .overflow     (overflow),
    .underflow    (underflow)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, miscompares=%0d", n_err);
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    mq.delete();
    m_ovf  = 1'b0;
    m_unf  = 1'b0;
    m_dout = '0;
    m_last = '0;
  endtask

  // One clock edge of FIFO behaviour, expressed on the queue.
  task automatic model_edge(input logic w, input logic r, input logic f, input logic [WIDTH-1:0] d);
    bit was_full;
    if (mq.size() > 0) m_last = mq[0];
    if (f) begin
      mq.delete();
      m_ovf = 1'b0;
      m_unf = 1'b0;
      return;
    end
    was_full = (mq.size() == DEPTH);
    if (r) begin
      if (mq.size() == 0) m_unf = 1'b1;
      else m_dout = mq.pop_front();
    end
    if (w) begin
      if (was_full && !r) m_ovf = 1'b1;
      else mq.push_back(d);
    end
  endtask

  task automatic check_all(input string where);
    logic [WIDTH-1:0] exp_dout;
`ifdef FIFO_FWFT_EN
    exp_dout = (mq.size() > 0) ? mq[0] : m_last;
`else
    exp_dout = m_dout;
`endif
    err_vec = '0;
    err_vec[ERR_OVF] = overflow;
    err_vec[ERR_UNF] = underflow;
    chk({where, " count"},        32'(count),        32'(mq.size()));
    chk({where, " full"},         32'(full),         32'(mq.size() == DEPTH));
    chk({where, " empty"},        32'(empty),        32'(mq.size() == 0));
    chk({where, " almost_full"},  32'(almost_full),  32'(mq.size() >= DEPTH - AF_MARGIN));
    chk({where, " almost_empty"}, 32'(almost_empty), 32'(mq.size() <= AE_MARGIN));
    chk({where, " err_status"},   32'(err_vec),      32'({m_unf, m_ovf}));
    chk({where, " data_out"},     32'(data_out),     32'(exp_dout));
  endtask

  task automatic step(input string where, input logic w, input logic r, input logic f,
                      input logic [WIDTH-1:0] d);
    @(negedge clk);
    wr = w; rd = r; flush = f; data_in = d;
    @(posedge clk);
    model_edge(w, r, f, d);
    #1;
    check_all(where);
  endtask

  initial begin
    rst = 1'b1; flush = 1'b0; wr = 1'b0; rd = 1'b0; data_in = '0;
    model_reset();
    repeat (2) @(negedge clk);
    check_all("reset");
    rst = 1'b0;

    for (int i = 0; i < DEPTH; i++) step("fill", 1'b1, 1'b0, 1'b0, 8'(i));
    step("overflow", 1'b1, 1'b0, 1'b0, 8'hAA);
    for (int i = 0; i < DEPTH; i++) step("drain", 1'b0, 1'b1, 1'b0, 8'($urandom));

    step("empty wr+rd", 1'b1, 1'b1, 1'b0, 8'h55);
    step("read 55", 1'b0, 1'b1, 1'b0, 8'h00);

    for (int i = 0; i < DEPTH; i++) step("refill", 1'b1, 1'b0, 1'b0, 8'($urandom));
    for (int i = 0; i < 20; i++) step("full concurrent", 1'b1, 1'b1, 1'b0, 8'(8'h80 + i));
    for (int i = 0; i < DEPTH; i++) step("drain wrap", 1'b0, 1'b1, 1'b0, 8'h00);

    for (int i = 0; i < 300; i++)
      step("random", 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
           1'($urandom_range(0, 39) == 0), 8'($urandom));

    step("pre-flush clear", 1'b0, 1'b0, 1'b1, 8'h00);
    for (int i = 0; i <= DEPTH; i++) step("flush setup wr", 1'b1, 1'b0, 1'b0, 8'($urandom));
    for (int i = 0; i < 9; i++) step("flush setup rd", 1'b0, 1'b1, 1'b0, 8'h00);
    chk("pre-flush count7", 32'(count), 32'd7);
    chk("pre-flush ovf", 32'(overflow), 32'd1);
    step("flush", 1'b1, 1'b1, 1'b1, 8'hEE);
    step("post-flush write", 1'b1, 1'b0, 1'b0, 8'h3C);
    step("post-flush read", 1'b0, 1'b1, 1'b0, 8'h00);

    for (int i = 0; i < 5; i++) step("pre-reset wr", 1'b1, 1'b0, 1'b0, 8'($urandom));
    step("pre-reset rd", 1'b0, 1'b1, 1'b0, 8'h00);
    step("pre-reset ovf", 1'b0, 1'b1, 1'b0, 8'h00);
    @(negedge clk);
    wr = 1'b1; rd = 1'b0; data_in = 8'h77;
    #2;
    rst = 1'b1;
    #1;
    model_reset();
    check_all("async reset");
    @(negedge clk);
    rst = 1'b0; wr = 1'b0;
    step("post-reset wr", 1'b1, 1'b0, 1'b0, 8'hC3);
    step("post-reset rd", 1'b0, 1'b1, 1'b0, 8'h00);
    step("post-reset unf", 1'b0, 1'b1, 1'b0, 8'h00);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/fifo_sync_param.md
Name: fifo_sync_param

Overview:
Parametrised single-clock FIFO; the next-generation storage DUT behind the fifo_if driver/monitor bench, replacing the fixed 8-bit FIFO.
- Generalised in width and depth.
- Adds an occupancy count, almost-full/almost-empty thresholds, sticky overflow/underflow error flags and a synchronous flush.
- Sits between a producer and a consumer in the same clock domain. Test benches drive it through the existing clocking-block style interface, widened to the new ports.

Parameters:
- WIDTH, 8, data word width in bits (1..256).
- DEPTH, 16, number of entries; must be a power of two, 2..4096; elaboration error otherwise.
- AF_MARGIN, 2, almost_full asserts when count >= DEPTH-AF_MARGIN.
- AE_MARGIN, 2, almost_empty asserts when count <= AE_MARGIN.

Ports:
- clk  input  1  rising-edge clock
- rst  input  1  asynchronous, active-high reset
- flush  input  1  synchronous clear of contents and error flags
- data_in  input  WIDTH  write data
- wr  input  1  write request
- rd  input  1  read request
- data_out  output  WIDTH  read data
- full  output  1  count == DEPTH
- empty  output  1  count == 0
- almost_full  output  1  threshold flag
- almost_empty  output  1  threshold flag
- count  output  $clog2(DEPTH)+1  current occupancy
- overflow  output  1  sticky: write dropped while full
- underflow  output  1  sticky: read attempted while empty

Behaviour:
Reset and pointers:
- Reset is asynchronous and active-high on rst; all state uses clk.
- Reset values: data_out=0, count=0, pointers=0, full=0, empty=1, almost_full=0, almost_empty=1, overflow=0, underflow=0.
- rd_ptr and wr_ptr are $clog2(DEPTH)+1 bits. The low bits address memory; the MSB is the wrap bit, so pointers wrap naturally at DEPTH.

Accepting writes and reads:
- Write accepted = wr && (!full || rd). Data stored at wr_ptr; wr_ptr++.
- Read accepted = rd && !empty. data_out <= mem[rd_ptr] registered, valid the cycle after rd (latency 1); rd_ptr++. data_out holds its value when no read is accepted.

Simultaneous and boundary cases:
- wr && rd, neither full nor empty: both accepted; count unchanged.
- wr && rd while full: both accepted; count stays DEPTH; full stays 1.
- wr && rd while empty: write only; rd sets underflow; count becomes 1. No read-through of the written word.
- wr while full without rd: data dropped, nothing changes, overflow <= 1.
- rd while empty: underflow <= 1.
- overflow and underflow stay set until rst or flush.

Flags:
- count, full, empty, almost_full and almost_empty are registered. All update in the same edge as the pointer change.
- full/empty derive from count or pointer compare (MSB differs, low bits equal means full).

flush:
- Highest priority after rst. Takes effect at the next edge: pointers, count and error flags are cleared.
- data_out is held, not cleared.
- Any wr/rd in the same cycle is ignored.

Reset mid-operation: all state is cleared immediately; memory contents are don't-care and never observable afterwards.

Optional Feature:
FIFO_FWFT_EN — first-word-fall-through.
- Defined: data_out presents the head entry whenever !empty, with no rd needed. rd acts as an acknowledge that pops the head; the next entry appears the following cycle. A write into an empty FIFO shows on data_out one cycle after the write edge.
- Undefined: standard mode, 1-cycle registered read as above.
- Flags, count and error behaviour are identical in both modes.

Decomposition:
- Package fifo_pkg holds:
  - a function returning the address width for a depth;
  - a localparam-checking helper for power-of-two depth;
  - an enum for the error status bits (ERR_OVF, ERR_UNF) used by benches and scoreboards.
- One sub-module, fifo_ram: a simple dual-port array, WIDTH x DEPTH, with a synchronous write port and an address/read port. No reset on the memory.
- fifo_sync_param holds the pointers, count, flags and the FWFT output stage.

Test Plan:
All scenarios use WIDTH=8, DEPTH=16.
- Fill and drain: write 0x00..0x0F, then read 16 times.
  - Writes: full=1 after the 16th write; almost_full=1 from count=14.
  - Reads: data_out returns 0x00..0x0F in order, each 1 cycle after rd; empty=1 and almost_empty=1 at count<=2.
- Overflow: from full, write 0xAA without rd -> count stays 16, overflow=1. Subsequent reads return no 0xAA.
- Underflow and simultaneous wr/rd on empty: from empty, pulse wr=1, rd=1 with data 0x55 -> underflow=1, count=1. The next read returns 0x55.
- Full concurrent and wrap: at full, wr=1/rd=1 for 20 cycles with an incrementing pattern -> count constant 16, no overflow, output order preserved across pointer wrap.
- Flush and reset: flush mid-stream at count=7 with overflow set -> next cycle count=0, empty=1, overflow=0. Assert rst asynchronously between edges -> outputs go to reset values immediately.
- FWFT build: write 0x3C into empty -> data_out=0x3C one cycle later, before any rd. rd pops it and empty=1 the next cycle.
